// File: rtl/instr_encoder.sv
// Encodes a small MIPS subset into 32-bit words and writes them sequentially
// into a 256-word instruction memory through a one-cycle write strobe.
module instr_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [4:0]  cmd_rs,
  input  logic [4:0]  cmd_rt,
  input  logic [4:0]  cmd_rd,
  input  logic [15:0] cmd_imm,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [31:0] mem_wdata,
  output logic [8:0]  count,
  output logic        full,
  output logic        err
);

  localparam int unsigned AW = 8;
  localparam int unsigned CW = 9;
  localparam int unsigned DEPTH = 256;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_SLT = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd8;
  localparam logic [3:0] OP_SW  = 4'd9;
  localparam logic [3:0] OP_BEQ = 4'd10;

  typedef enum logic [1:0] {IDLE, ENC, WRITE, FULL} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   ptr_q;
  logic [CW-1:0]   count_q;
  logic            op_ok_q;
  logic            accept;

  function automatic logic op_valid(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_LW, OP_SW, OP_BEQ: op_valid = 1'b1;
      default: op_valid = 1'b0;
    endcase
  endfunction

  // R-type carries the ALU function in funct; I-type carries a primary opcode.
  function automatic logic [31:0] encode(input logic [3:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [15:0] imm);
    logic [5:0] funct;
    logic [5:0] opcode;
    funct  = 6'b000000;
    opcode = 6'b000000;
    encode = 32'd0;
    case (op)
      OP_ADD: funct = 6'b100000;
      OP_SUB: funct = 6'b100010;
      OP_AND: funct = 6'b100100;
      OP_OR:  funct = 6'b100101;
      OP_SLT: funct = 6'b101010;
      OP_LW:  opcode = 6'b100011;
      OP_SW:  opcode = 6'b101011;
      OP_BEQ: opcode = 6'b000100;
      default: ;
    endcase
    if (op[3])
      encode = {opcode, rs, rt, imm};
    else
      encode = {6'b000000, rs, rt, rd, 5'b00000, funct};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and strobes; flush overrides every transition.
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    mem_we    = 1'b0;
    err       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!flush) begin
          cmd_ready = 1'b1;
          if (cmd_valid) state_d = ENC;
        end
      end
      ENC: begin
        if (op_ok_q) begin
          state_d = WRITE;
        end else begin
          err     = !flush;
          state_d = IDLE;
        end
      end
      WRITE: begin
        mem_we  = !flush;
        state_d = (count_q == CW'(DEPTH - 1)) ? FULL : IDLE;
      end
      FULL: ;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  assign accept = cmd_valid && cmd_ready;

  // Word and address are captured at accept so they stay stable through ENC and WRITE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q     <= '0;
      count_q   <= '0;
      op_ok_q   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (flush) begin
      ptr_q    <= '0;
      count_q  <= '0;
      op_ok_q  <= 1'b0;
      mem_addr <= '0;
    end else begin
      if (accept) begin
        op_ok_q   <= op_valid(cmd_op);
        mem_wdata <= encode(cmd_op, cmd_rs, cmd_rt, cmd_rd, cmd_imm);
        mem_addr  <= ptr_q;
      end
      if (state_q == WRITE) begin
        ptr_q   <= ptr_q + AW'(1);
        count_q <= count_q + CW'(1);
      end
    end
  end

  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench: expected writes are queued at issue time and a negedge
// monitor pops and compares them against every mem_we strobe.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op = '0;
  logic [4:0]  cmd_rs = '0, cmd_rt = '0, cmd_rd = '0;
  logic [15:0] cmd_imm = '0;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [8:0]  count;
  logic        full;
  logic        err;

  int vectors = 0;
  int miscompares = 0;
  logic [39:0] exp_q[$];
  int exp_count = 0;
  int exp_ptr = 0;

  instr_encoder dut (
    .clk(clk), .reset(reset), .flush(flush),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd), .cmd_imm(cmd_imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .count(count), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Write monitor
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      logic [39:0] e;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: addr 0x%02h data 0x%08h at %0t", mem_addr, mem_wdata, $time);
      end else begin
        e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== e) begin
          miscompares++;
          $display("FAIL write: got addr 0x%02h data 0x%08h expected addr 0x%02h data 0x%08h",
                   mem_addr, mem_wdata, e[39:32], e[31:0]);
        end
      end
    end
  end

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
    return {6'd0, rs, rt, rd, 5'd0, funct};
  endfunction

  task automatic push_exp(input logic [31:0] w);
    exp_q.push_back({8'(exp_ptr), w});
  endtask

  task automatic drive(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [15:0] imm);
    cmd_op = op; cmd_rs = rs; cmd_rt = rt; cmd_rd = rd; cmd_imm = imm;
    cmd_valid = 1'b1;
  endtask

  // Called at a negedge; returns 1ns after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [15:0] imm);
    int t = 0;
    while (cmd_ready !== 1'b1 && t < 8) begin
      @(negedge clk);
      t++;
    end
    if (cmd_ready !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL ready_timeout: cmd_ready stuck at %b", cmd_ready);
    end
    drive(op, rs, rt, rd, imm);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Walks ENC and WRITE after an accept, ends at the negedge back in IDLE/FULL.
  task automatic complete(input bit ok);
    @(negedge clk);
    chk("err_in_enc", 32'(err), 32'(!ok));
    if (ok) begin
      exp_count++;
      exp_ptr = (exp_ptr + 1) % 256;
      @(negedge clk);
      @(negedge clk);
      chk("count_after_write", 32'(count), 32'(exp_count));
    end else begin
      @(negedge clk);
      chk("err_cleared", 32'(err), 32'd0);
      chk("ready_after_err", 32'(cmd_ready), 32'd1);
      chk("count_after_err", 32'(count), 32'(exp_count));
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    exp_count = 0;
    exp_ptr = 0;
    @(negedge clk);
    chk("count_after_flush", 32'(count), 32'd0);
  endtask

  initial begin
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(cmd_ready), 32'd1);

    // ADD with a nonzero immediate that must be ignored
    push_exp(32'h0022_1820);
    issue(4'd0, 5'd1, 5'd2, 5'd3, 16'hBEEF);
    complete(1);

    do_flush();
    push_exp(32'h8FA8_0004);
    issue(4'd8, 5'd29, 5'd8, 5'd17, 16'h0004);
    complete(1);
    push_exp(32'h1085_FFFF);
    issue(4'd10, 5'd4, 5'd5, 5'd0, 16'hFFFF);
    complete(1);
    chk("count_two", 32'(count), 32'd2);

    issue(4'd5, 5'd1, 5'd1, 5'd1, 16'h0);
    complete(0);
    issue(4'd15, 5'd3, 5'd3, 5'd3, 16'h1234);
    complete(0);

    push_exp(32'h0085_3022);
    issue(4'd1, 5'd4, 5'd5, 5'd6, 16'h0);
    complete(1);
    push_exp(32'h00E8_4824);
    issue(4'd2, 5'd7, 5'd8, 5'd9, 16'h0);
    complete(1);
    push_exp(32'h03FF_F825);
    issue(4'd3, 5'd31, 5'd31, 5'd31, 16'hFFFF);
    complete(1);
    push_exp(32'h014B_602A);
    issue(4'd4, 5'd10, 5'd11, 5'd12, 16'h0);
    complete(1);
    push_exp(32'hAC43_0010);
    issue(4'd9, 5'd2, 5'd3, 5'd31, 16'h0010);
    complete(1);

    // Flush while the SUB sits in ENC, with a new command already waiting
    issue(4'd1, 5'd4, 5'd5, 5'd6, 16'h0);
    @(negedge clk);
    flush = 1'b1;
    drive(4'd3, 5'd31, 5'd31, 5'd31, 16'h0);
    chk("ready_during_flush", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    exp_count = 0;
    exp_ptr = 0;
    @(negedge clk);
    chk("count_flush_enc", 32'(count), 32'd0);
    push_exp(32'h03FF_F825);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    complete(1);

    do_flush();
    for (int i = 0; i < 256; i++) begin
      logic [4:0] rs, rt, rd;
      rs = 5'(i);
      rt = 5'(~i);
      rd = 5'(i + 7);
      push_exp(r_word(rs, rt, rd, 6'b100000));
      issue(4'd0, rs, rt, rd, 16'(i));
      complete(1);
    end
    chk("full_flag", 32'(full), 32'd1);
    chk("full_count", 32'(count), 32'd256);
    chk("full_ready", 32'(cmd_ready), 32'd0);

    // Held command in FULL must wait for flush
    drive(4'd0, 5'd3, 5'd4, 5'd5, 16'h0);
    repeat (3) begin
      @(negedge clk);
      chk("full_hold_ready", 32'(cmd_ready), 32'd0);
      chk("full_hold_count", 32'(count), 32'd256);
    end
    flush = 1'b1;
    chk("ready_flush_full", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    exp_count = 0;
    exp_ptr = 0;
    @(negedge clk);
    chk("count_after_full_flush", 32'(count), 32'd0);
    chk("full_cleared", 32'(full), 32'd0);
    chk("ready_after_full_flush", 32'(cmd_ready), 32'd1);
    push_exp(32'h0064_2820);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    complete(1);

    // Asynchronous reset in the middle of WRITE
    issue(4'd0, 5'd2, 5'd3, 5'd4, 16'h0);
    @(negedge clk);
    @(posedge clk);
    #2;
    chk("write_we_pre_reset", 32'(mem_we), 32'd1);
    chk("write_addr_pre_reset", 32'(mem_addr), 32'd1);
    chk("write_data_pre_reset", mem_wdata, 32'h0043_2020);
    reset = 1'b1;
    #1;
    chk("reset_we", 32'(mem_we), 32'd0);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_addr", 32'(mem_addr), 32'd0);
    chk("reset_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_count = 0;
    exp_ptr = 0;
    @(negedge clk);
    chk("ready_after_reset2", 32'(cmd_ready), 32'd1);
    push_exp(32'h0022_1820);
    issue(4'd0, 5'd1, 5'd2, 5'd3, 16'h0);
    complete(1);

    repeat (2) @(negedge clk);
    chk("pending_writes", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
